// File: rtl/xc_tx_arbiter.sv
// xc_tx_arbiter
// Round-robin arbiter that shares the UART transmitter between NUM_REQ packet
// sources. The grant is held for a whole packet. Each word is paced against the
// UART busy flag. A packet whose source stalls mid-packet for STALL_TIMEOUT
// cycles is aborted.
//
// Ports:
//   clki       system clock
//   reset      synchronous, active-high reset
//   enable     gates new grants only; a packet in progress always completes
//   req_valid  per-source "word ready"
//   req_data   per-source word, source i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_last   per-source "current word ends the packet"
//   req_ack    pop strobe to the granted source, coincident with tx_start
//   grant      one-hot owner of the transmitter, zero when idle
//   tx_data    registered word presented to the UART
//   tx_start   start strobe to the UART (combinational)
//   tx_busy    UART shifting flag
//   pkt_done   pulse when a packet ends on its last word
//   pkt_abort  pulse when a packet is dropped after a stall timeout
module xc_tx_arbiter #(
  parameter int NUM_REQ       = 8,
  parameter int WORD_WIDTH    = 8,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                          clki,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [WORD_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic                          pkt_done,
  output logic                          pkt_abort
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STALL_TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  state_t                state_reg;
  logic [NUM_REQ-1:0]    grant_reg;
  logic [PTR_W-1:0]      gidx_reg;
  logic [PTR_W-1:0]      rr_ptr_reg;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic                  wait_cnt_reg;
  logic                  last_q_reg;
  logic [WORD_WIDTH-1:0] tx_data_reg;
  logic                  pkt_done_reg;
  logic                  pkt_abort_reg;

  // Unpack the flat data bus into one word per source.
  logic [WORD_WIDTH-1:0] req_word [NUM_REQ];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // Round-robin pick: the first valid source at or after rr_ptr, wrapping.
  // The wrap is an explicit compare so that NUM_REQ need not be a power of two.
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // The source after the current owner gets top priority next time.
  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + 1'b1;

  // Start a word as soon as the owner has data and the UART is idle. This is
  // suppressed during reset so that a reset mid-packet never emits a strobe.
  logic fire;
  assign fire = !reset && (state_reg == ST_SEND) && req_valid[gidx_reg] && !tx_busy;

  assign tx_start  = fire;
  assign req_ack   = fire ? grant_reg : '0;
  assign grant     = grant_reg;
  assign tx_data   = tx_data_reg;
  assign pkt_done  = pkt_done_reg;
  assign pkt_abort = pkt_abort_reg;

  always_ff @(posedge clki) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      gidx_reg      <= '0;
      rr_ptr_reg    <= '0;
      stall_cnt_reg <= '0;
      wait_cnt_reg  <= 1'b0;
      last_q_reg    <= 1'b0;
      tx_data_reg   <= '0;
      pkt_done_reg  <= 1'b0;
      pkt_abort_reg <= 1'b0;
    end else begin
      pkt_done_reg  <= 1'b0;
      pkt_abort_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (enable && sel_found) begin
            grant_reg     <= NUM_REQ'(1) << sel_idx;
            gidx_reg      <= sel_idx;
            stall_cnt_reg <= '0;
            state_reg     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (fire) begin
            // The UART latches tx_data after the start strobe. The word is
            // held here until the next word is started.
            tx_data_reg   <= req_word[gidx_reg];
            last_q_reg    <= req_last[gidx_reg];
            stall_cnt_reg <= '0;
            wait_cnt_reg  <= 1'b0;
            state_reg     <= ST_WAIT_HI;
          end else if (!req_valid[gidx_reg]) begin
            if (stall_cnt_reg == STALL_LIMIT) begin
              pkt_abort_reg <= 1'b1;
              grant_reg     <= '0;
              rr_ptr_reg    <= next_ptr;
              state_reg     <= ST_IDLE;
            end else begin
              stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
          end
        end
        ST_WAIT_HI: begin
          // Busy may never show if the UART swallowed the word at once. Give
          // up after two cycles and let WAIT_LO see the idle flag.
          if (tx_busy || wait_cnt_reg) begin
            state_reg <= ST_WAIT_LO;
          end else begin
            wait_cnt_reg <= 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (last_q_reg) begin
              pkt_done_reg <= 1'b1;
              grant_reg    <= '0;
              rr_ptr_reg   <= next_ptr;
              state_reg    <= ST_IDLE;
            end else begin
              state_reg <= ST_SEND;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_tx_arbiter.sv
// Testbench for xc_tx_arbiter. Source FIFOs and a UART busy model drive the
// DUT. Stimulus pushes expected words and packet events into scoreboards, and
// a monitor checks them whenever the DUT strobes.
module tb_xc_tx_arbiter;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int STALL = 16;
  localparam int BUSY  = 10;

  logic           clki = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic           pkt_done;
  logic           pkt_abort;

  xc_tx_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W), .STALL_TIMEOUT(STALL)) dut (
    .clki(clki), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .pkt_done(pkt_done), .pkt_abort(pkt_abort)
  );

  always #5 clki = ~clki;

  typedef struct { int src; logic [7:0] data; } tx_t;
  typedef struct { int src; bit abort; } evt_t;

  tx_t        exp_tx[$];
  evt_t       exp_evt[$];
  logic [8:0] src_q [N][$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_tx = 0;
  int n_evt = 0;
  int last_tx_cyc = 0;
  int last_evt_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input bit last, input bit expect_it);
    tx_t t;
    src_q[s].push_back({last, d});
    if (expect_it) begin
      t.src = s;
      t.data = d;
      exp_tx.push_back(t);
    end
  endtask

  task automatic ev(input int s, input bit abort);
    evt_t e;
    e.src = s;
    e.abort = abort;
    exp_evt.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic wait_evt(input int n, input string nm);
    int c = 0;
    while (n_evt < n && c < 3000) begin
      @(negedge clki);
      c++;
    end
    chk(nm, n_evt, n);
  endtask

  task automatic wait_tx(input int n, input string nm);
    int c = 0;
    while (n_tx < n && c < 3000) begin
      @(negedge clki);
      c++;
    end
    chk(nm, n_tx, n);
  endtask

  always @(posedge clki) cyc++;

  // Source FIFOs and UART busy model: sample strobes mid-cycle and update
  // the inputs just after the clock edge.
  initial begin
    logic [N-1:0] ack_s;
    logic         start_s;
    int           busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clki);
      ack_s = req_ack;
      start_s = tx_start;
      @(posedge clki);
      for (int i = 0; i < N; i++) begin
        if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      #1;
      if (start_s) busy_cnt = BUSY;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt != 0);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = src_q[i][0][7:0];
          req_last[i] = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*W +: W] = '0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT strobes.
  initial begin
    tx_t        e;
    evt_t       v;
    bit         pend_data;
    logic [7:0] pend_val;
    int         owner;
    pend_data = 0;
    pend_val = '0;
    owner = -1;
    forever begin
      @(negedge clki);
      if (pend_data) begin
        chk("tx_data", tx_data, pend_val);
        pend_data = 0;
      end
      if (tx_start) begin
        if (exp_tx.size() == 0) begin
          chk("unexpected_tx_start", tx_start, 0);
        end else begin
          e = exp_tx.pop_front();
          $display("tx  cycle=%0d src=%0d data=%02h grant=%02h", cyc, e.src, e.data, grant);
          chk("tx_grant", grant, 1 << e.src);
          chk("tx_ack", req_ack, 1 << e.src);
          pend_data = 1;
          pend_val = e.data;
          n_tx++;
          last_tx_cyc = cyc;
        end
      end else if (req_ack != 0) begin
        chk("stray_ack", req_ack, 0);
      end
      if (pkt_done || pkt_abort) begin
        if (exp_evt.size() == 0) begin
          chk("unexpected_evt", {pkt_done, pkt_abort}, 0);
        end else begin
          v = exp_evt.pop_front();
          $display("evt cycle=%0d src=%0d kind=%s", cyc, owner, pkt_abort ? "abort" : "done");
          chk("evt_kind", {pkt_done, pkt_abort}, v.abort ? 1 : 2);
          chk("evt_src", owner, v.src);
          chk("evt_grant", grant, 0);
          n_evt++;
          last_evt_cyc = cyc;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (grant[i]) owner = i;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int g;
    // Reset values
    tick(3);
    @(negedge clki);
    chk("rst_grant", grant, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_done_abort", {pkt_done, pkt_abort}, 0);
    chk("rst_rr_ptr", dut.rr_ptr_reg, 0);
    @(posedge clki); #1;
    reset = 1'b0;
    tick(2);

    // Contention: sources 0,3,7 with two 1-word packets each.
    push(0, 8'h10, 1, 1); push(3, 8'h30, 1, 1); push(7, 8'h70, 1, 1);
    push(0, 8'h11, 1, 1); push(3, 8'h31, 1, 1); push(7, 8'h71, 1, 1);
    ev(0, 0); ev(3, 0); ev(7, 0); ev(0, 0); ev(3, 0); ev(7, 0);
    wait_evt(6, "contention_done");
    chk("rr_after_contention", dut.rr_ptr_reg, 0);

    // Single source, three-word packet.
    push(2, 8'hA5, 0, 1); push(2, 8'h5A, 0, 1); push(2, 8'hFF, 1, 1);
    ev(2, 0);
    wait_evt(7, "single_done");
    chk("rr_after_single", dut.rr_ptr_reg, 3);

    // Wrap: source 6 leaves rr_ptr at 7, then source 1 alone wins.
    push(6, 8'h66, 1, 1); ev(6, 0);
    wait_evt(8, "src6_done");
    chk("rr_after_src6", dut.rr_ptr_reg, 7);
    push(1, 8'h11, 1, 1); ev(1, 0);
    wait_evt(9, "wrap_done");
    chk("rr_after_wrap", dut.rr_ptr_reg, 2);

    // Stall: one non-last word, then nothing. Abort lands 1+1+9+1 cycles to
    // re-enter SEND, plus 16 stalled cycles = 28 after tx_start.
    push(4, 8'h44, 0, 1); ev(4, 1);
    wait_evt(10, "stall_abort");
    chk("stall_latency", last_evt_cyc - last_tx_cyc, 28);
    chk("stall_grant", grant, 0);
    chk("rr_after_stall", dut.rr_ptr_reg, 5);

    // Enable dropped mid-packet: packet completes, no new grant until enable.
    push(5, 8'h50, 0, 1); push(5, 8'h51, 0, 1); push(5, 8'h52, 0, 1); push(5, 8'h53, 1, 1);
    ev(5, 0);
    base = n_tx;
    wait_tx(base + 1, "en_first_word");
    @(posedge clki); #1;
    enable = 1'b0;
    push(6, 8'h60, 1, 1); ev(6, 0);
    wait_evt(11, "en_pkt_done");
    g = 0;
    repeat (20) begin
      @(negedge clki);
      if (grant != 0) g++;
    end
    chk("no_grant_disabled", g, 0);
    @(posedge clki); #1;
    enable = 1'b1;
    @(negedge clki);
    @(negedge clki);
    chk("grant_after_enable", grant, 8'h40);
    wait_evt(12, "en_src6_done");

    // Reset while in WAIT_LO: packet abandoned, no pkt_done.
    push(3, 8'h33, 0, 1); push(3, 8'h34, 1, 0);
    base = n_tx;
    wait_tx(base + 1, "rst_first_word");
    tick(4);
    reset = 1'b1;
    src_q[3].delete();
    @(negedge clki);
    chk("rst_mid_tx_start", tx_start, 0);
    @(posedge clki); #1;
    reset = 1'b0;
    @(negedge clki);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_tx_start2", tx_start, 0);
    chk("rst_mid_rr", dut.rr_ptr_reg, 0);
    chk("rst_mid_done", pkt_done, 0);
    tick(15);
    chk("final_evt_count", n_evt, 12);
    chk("exp_tx_left", exp_tx.size(), 0);
    chk("exp_evt_left", exp_evt.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
